// File: rtl/uart_sv_core.sv
// Full-duplex UART core with a shared baud tick, even-parity framing, Rx FIFO, RTS/CTS flow control
// and an internal loopback self-test that exercises the Tx and Rx paths without touching the pins.
module uart_sv_core #(
    parameter int SYSCLK_RATE = 4,
    parameter int BAUD_RATE   = 1,
    parameter int DATA_BITS   = 8,
    parameter int STOP_BITS   = 2,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                 SysClk,
    input  logic                 Rst,
    input  logic                 Rx,
    input  logic                 CTS,
    output logic                 Tx,
    output logic                 RTS,
    input  logic [DATA_BITS-1:0] Tx_Data,
    input  logic                 Transmit_Start,
    output logic                 Tx_Busy,
    output logic [DATA_BITS-1:0] Data_Out,
    input  logic                 Read_Done,
    output logic                 FIFO_Empty,
    output logic                 FIFO_Full,
    output logic                 Data_Rdy,
    output logic [2:0]           Rx_Error,
    input  logic                 BIST_Start,
    output logic                 BIST_Busy,
    output logic                 BIST_Error
);

    localparam int DIV   = SYSCLK_RATE / BAUD_RATE;
    localparam int HALF  = DIV / 2;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BC_W  = $clog2(DATA_BITS + STOP_BITS + 1);
    localparam int AW    = $clog2(FIFO_DEPTH);

    localparam logic [2:0] TX_IDLE   = 3'd0;
    localparam logic [2:0] TX_START  = 3'd1;
    localparam logic [2:0] TX_DATA   = 3'd2;
    localparam logic [2:0] TX_PARITY = 3'd3;
    localparam logic [2:0] TX_STOP   = 3'd4;

    localparam logic [2:0] RX_IDLE   = 3'd0;
    localparam logic [2:0] RX_START  = 3'd1;
    localparam logic [2:0] RX_DATA   = 3'd2;
    localparam logic [2:0] RX_PARITY = 3'd3;
    localparam logic [2:0] RX_STOP   = 3'd4;

    localparam logic [1:0] B_IDLE = 2'd0;
    localparam logic [1:0] B_SEND = 2'd1;
    localparam logic [1:0] B_WAIT = 2'd2;

    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

    // Self-test bytes 0x55, 0xAA, 0x00, 0xFF generalised to any data width.
    function automatic logic [DATA_BITS-1:0] bist_pattern(input logic [1:0] idx);
        logic [DATA_BITS-1:0] p;
        p = '0;
        for (int i = 0; i < DATA_BITS; i++) begin
            case (idx)
                2'd0:    p[i] = ~i[0];
                2'd1:    p[i] = i[0];
                2'd2:    p[i] = 1'b0;
                default: p[i] = 1'b1;
            endcase
        end
        return p;
    endfunction

    logic [CNT_W-1:0]     baud_cnt_r;
    logic                 tick_s;

    logic [2:0]           tx_state_r;
    logic [DATA_BITS-1:0] tx_shift_r;
    logic                 tx_par_r;
    logic [BC_W-1:0]      tx_cnt_r;
    logic                 tx_bit_r;
    logic                 tx_pin_r;
    logic                 tx_loop_r;
    logic                 tx_busy_r;

    logic                 rx_meta_r;
    logic                 rx_sync_r;
    logic                 rx_prev_r;
    logic                 rx_line_s;
    logic [2:0]           rx_state_r;
    logic [CNT_W-1:0]     rx_cnt_r;
    logic [BC_W-1:0]      rx_bits_r;
    logic [DATA_BITS-1:0] rx_shift_r;
    logic                 rx_par_r;
    logic                 rx_stop_ok_r;
    logic                 rx_done_r;
    logic [DATA_BITS-1:0] rx_data_r;
    logic                 rx_perr_r;
    logic                 rx_ferr_r;
    logic [2:0]           rx_error_r;

    logic [1:0]           bist_state_r;
    logic [1:0]           bist_idx_r;
    logic                 bist_busy_r;
    logic                 bist_err_r;
    logic                 bist_go_s;
    logic                 bist_req_s;
    logic                 user_go_s;

    logic [DATA_BITS-1:0] fifo_mem_r [FIFO_DEPTH];
    logic [AW:0]          wr_ptr_r;
    logic [AW:0]          rd_ptr_r;
    logic [AW:0]          wr_ptr_s;
    logic [AW:0]          rd_ptr_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 fifo_full_r;
    logic                 fifo_empty_r;
    logic                 data_rdy_r;
    logic                 rts_r;
    logic [DATA_BITS-1:0] data_out_r;

    assign tick_s     = (baud_cnt_r == CNT_W'(DIV - 1));
    assign bist_go_s  = (bist_state_r == B_IDLE) && BIST_Start &&
                        (tx_state_r == TX_IDLE) && (rx_state_r == RX_IDLE);
    assign bist_req_s = (bist_state_r == B_SEND) && (tx_state_r == TX_IDLE);
    assign user_go_s  = (tx_state_r == TX_IDLE) && Transmit_Start && CTS &&
                        !bist_busy_r && !bist_go_s;
    // During self-test the receiver listens to the internal Tx line instead of the pin.
    assign rx_line_s  = bist_busy_r ? tx_bit_r : rx_sync_r;

    // Free-running baud divider; all Tx bit boundaries land on its wrap tick.
    always_ff @(posedge SysClk or negedge Rst) begin
        if (!Rst) begin
            baud_cnt_r <= '0;
        end else if (tick_s) begin
            baud_cnt_r <= '0;
        end else begin
            baud_cnt_r <= baud_cnt_r + CNT_W'(1);
        end
    end

    // Transmit FSM; tx_bit_r is the internal line, tx_pin_r the pin (held high for loopback frames).
    always_ff @(posedge SysClk or negedge Rst) begin
        if (!Rst) begin
            tx_state_r <= TX_IDLE;
            tx_shift_r <= '0;
            tx_par_r   <= 1'b0;
            tx_cnt_r   <= '0;
            tx_bit_r   <= 1'b1;
            tx_pin_r   <= 1'b1;
            tx_loop_r  <= 1'b0;
            tx_busy_r  <= 1'b0;
        end else begin
            case (tx_state_r)
                TX_IDLE: begin
                    if (bist_req_s) begin
                        tx_shift_r <= bist_pattern(bist_idx_r);
                        tx_par_r   <= parity_of(bist_pattern(bist_idx_r));
                        tx_loop_r  <= 1'b1;
                        tx_busy_r  <= 1'b1;
                        tx_state_r <= TX_START;
                    end else if (user_go_s) begin
                        tx_shift_r <= Tx_Data;
                        tx_par_r   <= parity_of(Tx_Data);
                        tx_loop_r  <= 1'b0;
                        tx_busy_r  <= 1'b1;
                        tx_state_r <= TX_START;
                    end
                end
                TX_START: begin
                    if (tick_s) begin
                        tx_bit_r   <= 1'b0;
                        tx_pin_r   <= tx_loop_r;
                        tx_cnt_r   <= '0;
                        tx_state_r <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (tick_s) begin
                        tx_bit_r   <= tx_shift_r[DATA_BITS-1];
                        tx_pin_r   <= tx_loop_r | tx_shift_r[DATA_BITS-1];
                        tx_shift_r <= {tx_shift_r[DATA_BITS-2:0], 1'b0};
                        if (tx_cnt_r == BC_W'(DATA_BITS - 1)) begin
                            tx_state_r <= TX_PARITY;
                        end else begin
                            tx_cnt_r <= tx_cnt_r + BC_W'(1);
                        end
                    end
                end
                TX_PARITY: begin
                    if (tick_s) begin
                        tx_bit_r   <= tx_par_r;
                        tx_pin_r   <= tx_loop_r | tx_par_r;
                        tx_cnt_r   <= '0;
                        tx_state_r <= TX_STOP;
                    end
                end
                TX_STOP: begin
                    if (tick_s) begin
                        // One extra tick closes the final stop-bit period before releasing busy.
                        if (tx_cnt_r == BC_W'(STOP_BITS)) begin
                            tx_busy_r  <= 1'b0;
                            tx_loop_r  <= 1'b0;
                            tx_state_r <= TX_IDLE;
                        end else begin
                            tx_bit_r <= 1'b1;
                            tx_pin_r <= 1'b1;
                            tx_cnt_r <= tx_cnt_r + BC_W'(1);
                        end
                    end
                end
                default: begin
                    tx_state_r <= TX_IDLE;
                    tx_bit_r   <= 1'b1;
                    tx_pin_r   <= 1'b1;
                    tx_busy_r  <= 1'b0;
                    tx_loop_r  <= 1'b0;
                end
            endcase
        end
    end

    // Two-flop synchroniser for the external Rx pin plus edge history of the selected line.
    always_ff @(posedge SysClk or negedge Rst) begin
        if (!Rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= Rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_line_s;
        end
    end

    // Receive FSM: half-bit start recheck, then centre sampling every DIV cycles.
    always_ff @(posedge SysClk or negedge Rst) begin
        if (!Rst) begin
            rx_state_r   <= RX_IDLE;
            rx_cnt_r     <= '0;
            rx_bits_r    <= '0;
            rx_shift_r   <= '0;
            rx_par_r     <= 1'b0;
            rx_stop_ok_r <= 1'b1;
            rx_done_r    <= 1'b0;
            rx_data_r    <= '0;
            rx_perr_r    <= 1'b0;
            rx_ferr_r    <= 1'b0;
        end else begin
            rx_done_r <= 1'b0;
            case (rx_state_r)
                RX_IDLE: begin
                    if (rx_prev_r && !rx_line_s) begin
                        rx_cnt_r   <= '0;
                        rx_state_r <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt_r == CNT_W'(HALF - 1)) begin
                        rx_cnt_r   <= '0;
                        rx_bits_r  <= '0;
                        rx_state_r <= rx_line_s ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_r <= rx_cnt_r + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_r == CNT_W'(DIV - 1)) begin
                        rx_cnt_r   <= '0;
                        rx_shift_r <= {rx_shift_r[DATA_BITS-2:0], rx_line_s};
                        if (rx_bits_r == BC_W'(DATA_BITS - 1)) begin
                            rx_state_r <= RX_PARITY;
                        end else begin
                            rx_bits_r <= rx_bits_r + BC_W'(1);
                        end
                    end else begin
                        rx_cnt_r <= rx_cnt_r + CNT_W'(1);
                    end
                end
                RX_PARITY: begin
                    if (rx_cnt_r == CNT_W'(DIV - 1)) begin
                        rx_cnt_r     <= '0;
                        rx_par_r     <= rx_line_s;
                        rx_stop_ok_r <= 1'b1;
                        rx_bits_r    <= '0;
                        rx_state_r   <= RX_STOP;
                    end else begin
                        rx_cnt_r <= rx_cnt_r + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_r == CNT_W'(DIV - 1)) begin
                        rx_cnt_r <= '0;
                        if (rx_bits_r == BC_W'(STOP_BITS - 1)) begin
                            rx_done_r  <= 1'b1;
                            rx_data_r  <= rx_shift_r;
                            rx_perr_r  <= parity_of(rx_shift_r) ^ rx_par_r;
                            rx_ferr_r  <= !(rx_stop_ok_r && rx_line_s);
                            rx_state_r <= RX_IDLE;
                        end else begin
                            rx_stop_ok_r <= rx_stop_ok_r & rx_line_s;
                            rx_bits_r    <= rx_bits_r + BC_W'(1);
                        end
                    end else begin
                        rx_cnt_r <= rx_cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    rx_state_r <= RX_IDLE;
                end
            endcase
        end
    end

    // Self-test sequencer: send each pattern over loopback and compare what comes back.
    always_ff @(posedge SysClk or negedge Rst) begin
        if (!Rst) begin
            bist_state_r <= B_IDLE;
            bist_idx_r   <= 2'd0;
            bist_busy_r  <= 1'b0;
            bist_err_r   <= 1'b0;
        end else begin
            case (bist_state_r)
                B_IDLE: begin
                    if (bist_go_s) begin
                        bist_busy_r  <= 1'b1;
                        bist_err_r   <= 1'b0;
                        bist_idx_r   <= 2'd0;
                        bist_state_r <= B_SEND;
                    end
                end
                B_SEND: begin
                    if (bist_req_s) begin
                        bist_state_r <= B_WAIT;
                    end
                end
                B_WAIT: begin
                    if (rx_done_r) begin
                        if ((rx_data_r != bist_pattern(bist_idx_r)) || rx_perr_r || rx_ferr_r) begin
                            bist_err_r <= 1'b1;
                        end
                        if (bist_idx_r == 2'd3) begin
                            bist_busy_r  <= 1'b0;
                            bist_state_r <= B_IDLE;
                        end else begin
                            bist_idx_r   <= bist_idx_r + 2'd1;
                            bist_state_r <= B_SEND;
                        end
                    end
                end
                default: begin
                    bist_state_r <= B_IDLE;
                    bist_busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign push_s = rx_done_r && !bist_busy_r && !fifo_full_r;
    assign pop_s  = Read_Done && !fifo_empty_r;

    // Next FIFO pointers, used to register full/empty without a cycle of lag.
    always_comb begin
        wr_ptr_s = wr_ptr_r;
        rd_ptr_s = rd_ptr_r;
        if (push_s) begin
            wr_ptr_s = wr_ptr_r + (AW + 1)'(1);
        end else begin
            wr_ptr_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_ptr_s = rd_ptr_r + (AW + 1)'(1);
        end else begin
            rd_ptr_s = rd_ptr_r;
        end
    end

    // FIFO storage; contents need no reset because the pointers qualify every read.
    always_ff @(posedge SysClk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r[AW-1:0]] <= rx_data_r;
        end
    end

    // FIFO pointers, status flags, read data and per-frame error report.
    always_ff @(posedge SysClk or negedge Rst) begin
        if (!Rst) begin
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            fifo_full_r  <= 1'b0;
            fifo_empty_r <= 1'b1;
            data_rdy_r   <= 1'b0;
            rts_r        <= 1'b1;
            data_out_r   <= '0;
            rx_error_r   <= 3'b000;
        end else begin
            wr_ptr_r     <= wr_ptr_s;
            rd_ptr_r     <= rd_ptr_s;
            fifo_empty_r <= (wr_ptr_s == rd_ptr_s);
            data_rdy_r   <= (wr_ptr_s != rd_ptr_s);
            fifo_full_r  <= (wr_ptr_s[AW] != rd_ptr_s[AW]) && (wr_ptr_s[AW-1:0] == rd_ptr_s[AW-1:0]);
            rts_r        <= !((wr_ptr_s[AW] != rd_ptr_s[AW]) && (wr_ptr_s[AW-1:0] == rd_ptr_s[AW-1:0]));
            if (pop_s) begin
                data_out_r <= fifo_mem_r[rd_ptr_r[AW-1:0]];
            end
            if (rx_done_r && !bist_busy_r) begin
                rx_error_r <= {fifo_full_r, rx_ferr_r, rx_perr_r};
            end
        end
    end

    assign Tx         = tx_pin_r;
    assign Tx_Busy    = tx_busy_r;
    assign RTS        = rts_r;
    assign Data_Out   = data_out_r;
    assign FIFO_Empty = fifo_empty_r;
    assign FIFO_Full  = fifo_full_r;
    assign Data_Rdy   = data_rdy_r;
    assign Rx_Error   = rx_error_r;
    assign BIST_Busy  = bist_busy_r;
    assign BIST_Error = bist_err_r;

endmodule

// File: tb/tb_uart_sv_core.sv
// Directed bench for uart_sv_core: Tx framing, CTS hold, Rx/FIFO behaviour, error flags and BIST.
module tb_uart_sv_core;

    logic       SysClk;
    logic       Rst;
    logic       Rx;
    logic       CTS;
    logic       Tx;
    logic       RTS;
    logic [7:0] Tx_Data;
    logic       Transmit_Start;
    logic       Tx_Busy;
    logic [7:0] Data_Out;
    logic       Read_Done;
    logic       FIFO_Empty;
    logic       FIFO_Full;
    logic       Data_Rdy;
    logic [2:0] Rx_Error;
    logic       BIST_Start;
    logic       BIST_Busy;
    logic       BIST_Error;

    int errors = 0;
    int checks = 0;

    uart_sv_core dut (
        .SysClk(SysClk), .Rst(Rst), .Rx(Rx), .CTS(CTS), .Tx(Tx), .RTS(RTS),
        .Tx_Data(Tx_Data), .Transmit_Start(Transmit_Start), .Tx_Busy(Tx_Busy),
        .Data_Out(Data_Out), .Read_Done(Read_Done), .FIFO_Empty(FIFO_Empty),
        .FIFO_Full(FIFO_Full), .Data_Rdy(Data_Rdy), .Rx_Error(Rx_Error),
        .BIST_Start(BIST_Start), .BIST_Busy(BIST_Busy), .BIST_Error(BIST_Error)
    );

    initial SysClk = 1'b0;
    always #5 SysClk = ~SysClk;

    task automatic test_reset;
        Rst = 1'b0;
        repeat (3) @(negedge SysClk);
        Rst = 1'b1;
        @(negedge SysClk);
        checks++; if (Tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", Tx); end
        checks++; if (Tx_Busy !== 1'b0) begin errors++; $display("FAIL reset_tx_busy: got %b want 0", Tx_Busy); end
        checks++; if (Data_Out !== 8'h00) begin errors++; $display("FAIL reset_data_out: got %h want 00", Data_Out); end
        checks++; if (FIFO_Empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", FIFO_Empty); end
        checks++; if (Data_Rdy !== 1'b0) begin errors++; $display("FAIL reset_data_rdy: got %b want 0", Data_Rdy); end
        checks++; if (FIFO_Full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", FIFO_Full); end
        checks++; if (RTS !== 1'b1) begin errors++; $display("FAIL reset_rts: got %b want 1", RTS); end
        checks++; if (Rx_Error !== 3'b000) begin errors++; $display("FAIL reset_rx_error: got %b want 000", Rx_Error); end
        checks++; if (BIST_Busy !== 1'b0) begin errors++; $display("FAIL reset_bist_busy: got %b want 0", BIST_Busy); end
        checks++; if (BIST_Error !== 1'b0) begin errors++; $display("FAIL reset_bist_error: got %b want 0", BIST_Error); end
    endtask

    task automatic test_tx_frame(input logic [7:0] data, input logic [11:0] frame);
        logic seen;
        seen = 1'b0;
        Tx_Data = data;
        Transmit_Start = 1'b1;
        @(negedge SysClk);
        checks++; if (Tx_Busy !== 1'b1) begin errors++; $display("FAIL tx_busy_accept %h: got %b want 1", data, Tx_Busy); end
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge SysClk);
            if (Tx === 1'b0) seen = 1'b1;
        end
        Transmit_Start = 1'b0;
        checks++;
        if (!seen) begin
            errors++; $display("FAIL tx_start_timeout %h: got no start bit, want one within 20 cycles", data);
        end else begin
            repeat (2) @(negedge SysClk);
            for (int b = 11; b >= 0; b--) begin
                checks++; if (Tx !== frame[b]) begin errors++; $display("FAIL tx_bit %h pos %0d: got %b want %b", data, 11 - b, Tx, frame[b]); end
                checks++; if (Tx_Busy !== 1'b1) begin errors++; $display("FAIL tx_busy_span %h pos %0d: got %b want 1", data, 11 - b, Tx_Busy); end
                if (b != 0) repeat (4) @(negedge SysClk);
            end
            repeat (2) @(negedge SysClk);
            checks++; if (Tx_Busy !== 1'b0) begin errors++; $display("FAIL tx_busy_end %h: got %b want 0", data, Tx_Busy); end
        end
    endtask

    task automatic test_cts_hold;
        int bad;
        bad = 0;
        CTS = 1'b0;
        Tx_Data = 8'h3C;
        Transmit_Start = 1'b1;
        repeat (24) begin
            @(negedge SysClk);
            if (Tx !== 1'b1 || Tx_Busy !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL cts_hold: got %0d cycles with Tx low or busy, want 0", bad); end
        CTS = 1'b1;
        test_tx_frame(8'h3C, 12'b0_00111100_0_11);
    endtask

    task automatic drive_rx(input logic [7:0] data, input logic par, input logic [1:0] stops);
        logic [11:0] bits;
        bits = {1'b0, data, par, stops};
        for (int i = 11; i >= 0; i--) begin
            Rx = bits[i];
            repeat (4) @(negedge SysClk);
        end
        Rx = 1'b1;
        repeat (8) @(negedge SysClk);
    endtask

    task automatic read_pulse;
        Read_Done = 1'b1;
        @(negedge SysClk);
        Read_Done = 1'b0;
    endtask

    task automatic test_rx_basic;
        drive_rx(8'hAA, 1'b0, 2'b11);
        checks++; if (Data_Rdy !== 1'b1) begin errors++; $display("FAIL rx_data_rdy: got %b want 1", Data_Rdy); end
        checks++; if (Rx_Error !== 3'b000) begin errors++; $display("FAIL rx_clean_error: got %b want 000", Rx_Error); end
        read_pulse();
        checks++; if (Data_Out !== 8'hAA) begin errors++; $display("FAIL rx_data_out: got %h want aa", Data_Out); end
        checks++; if (FIFO_Empty !== 1'b1) begin errors++; $display("FAIL rx_empty_after_read: got %b want 1", FIFO_Empty); end
        checks++; if (Data_Rdy !== 1'b0) begin errors++; $display("FAIL rx_rdy_after_read: got %b want 0", Data_Rdy); end
    endtask

    task automatic test_rx_errors;
        drive_rx(8'hAA, 1'b1, 2'b11);
        checks++; if (Rx_Error !== 3'b001) begin errors++; $display("FAIL rx_parity_err: got %b want 001", Rx_Error); end
        read_pulse();
        checks++; if (Data_Out !== 8'hAA) begin errors++; $display("FAIL rx_parity_byte: got %h want aa", Data_Out); end
        drive_rx(8'h0F, 1'b0, 2'b01);
        checks++; if (Rx_Error !== 3'b010) begin errors++; $display("FAIL rx_framing_err: got %b want 010", Rx_Error); end
        read_pulse();
        checks++; if (Data_Out !== 8'h0F) begin errors++; $display("FAIL rx_framing_byte: got %h want 0f", Data_Out); end
        drive_rx(8'h5A, 1'b0, 2'b11);
        checks++; if (Rx_Error !== 3'b000) begin errors++; $display("FAIL rx_error_clear: got %b want 000", Rx_Error); end
        read_pulse();
        checks++; if (Data_Out !== 8'h5A) begin errors++; $display("FAIL rx_clean_byte: got %h want 5a", Data_Out); end
    endtask

    task automatic test_fifo_full;
        logic [7:0] v;
        for (int i = 0; i < 8; i++) begin
            v = 8'(i);
            drive_rx(v, ^v, 2'b11);
        end
        checks++; if (FIFO_Full !== 1'b1) begin errors++; $display("FAIL fifo_full: got %b want 1", FIFO_Full); end
        checks++; if (RTS !== 1'b0) begin errors++; $display("FAIL fifo_rts_low: got %b want 0", RTS); end
        checks++; if (Rx_Error !== 3'b000) begin errors++; $display("FAIL fifo_fill_error: got %b want 000", Rx_Error); end
        drive_rx(8'h08, 1'b1, 2'b11);
        checks++; if (Rx_Error !== 3'b100) begin errors++; $display("FAIL fifo_overrun: got %b want 100", Rx_Error); end
        for (int i = 0; i < 8; i++) begin
            read_pulse();
            checks++; if (Data_Out !== 8'(i)) begin errors++; $display("FAIL fifo_read %0d: got %h want %h", i, Data_Out, 8'(i)); end
        end
        checks++; if (FIFO_Empty !== 1'b1) begin errors++; $display("FAIL fifo_drained: got %b want 1", FIFO_Empty); end
        checks++; if (RTS !== 1'b1) begin errors++; $display("FAIL fifo_rts_high: got %b want 1", RTS); end
        read_pulse();
        checks++; if (Data_Out !== 8'h07) begin errors++; $display("FAIL fifo_read_empty: got %h want 07", Data_Out); end
    endtask

    task automatic test_reset_midframe;
        logic seen;
        seen = 1'b0;
        Tx_Data = 8'h00;
        Transmit_Start = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge SysClk);
            if (Tx === 1'b0) seen = 1'b1;
        end
        Transmit_Start = 1'b0;
        repeat (6) @(negedge SysClk);
        checks++; if (!seen || Tx !== 1'b0) begin errors++; $display("FAIL midframe_tx_low: got %b want 0", Tx); end
        #1 Rst = 1'b0;
        #1;
        checks++; if (Tx !== 1'b1) begin errors++; $display("FAIL midframe_reset_tx: got %b want 1", Tx); end
        checks++; if (Tx_Busy !== 1'b0) begin errors++; $display("FAIL midframe_reset_busy: got %b want 0", Tx_Busy); end
        checks++; if (Data_Out !== 8'h00) begin errors++; $display("FAIL midframe_reset_data: got %h want 00", Data_Out); end
        @(negedge SysClk);
        Rst = 1'b1;
        repeat (2) @(negedge SysClk);
    endtask

    task automatic test_bist(input logic corrupt, input logic exp_err);
        logic tx_low;
        logic done;
        tx_low = 1'b0;
        done = 1'b0;
        BIST_Start = 1'b1;
        @(negedge SysClk);
        BIST_Start = 1'b0;
        checks++; if (BIST_Busy !== 1'b1) begin errors++; $display("FAIL bist_busy_start: got %b want 1", BIST_Busy); end
        checks++; if (BIST_Error !== 1'b0) begin errors++; $display("FAIL bist_error_cleared: got %b want 0", BIST_Error); end
        for (int i = 0; i < 2000 && !done; i++) begin
            if (corrupt && i == 12) force dut.rx_line_s = 1'b0;
            if (corrupt && i == 20) release dut.rx_line_s;
            @(negedge SysClk);
            if (Tx !== 1'b1) tx_low = 1'b1;
            if (BIST_Busy === 1'b0) done = 1'b1;
        end
        checks++; if (!done) begin errors++; $display("FAIL bist_timeout: got busy after 2000 cycles, want done"); end
        checks++; if (tx_low) begin errors++; $display("FAIL bist_tx_pin: got Tx low, want held 1"); end
        checks++; if (BIST_Error !== exp_err) begin errors++; $display("FAIL bist_result: got %b want %b", BIST_Error, exp_err); end
        checks++; if (FIFO_Empty !== 1'b1) begin errors++; $display("FAIL bist_fifo_untouched: got %b want 1", FIFO_Empty); end
        repeat (10) @(negedge SysClk);
        checks++; if (BIST_Error !== exp_err) begin errors++; $display("FAIL bist_sticky: got %b want %b", BIST_Error, exp_err); end
    endtask

    initial begin
        Rst = 1'b0;
        Rx = 1'b1;
        CTS = 1'b1;
        Tx_Data = 8'h00;
        Transmit_Start = 1'b0;
        Read_Done = 1'b0;
        BIST_Start = 1'b0;
        test_reset();
        test_tx_frame(8'hBB, 12'b0_10111011_0_11);
        test_tx_frame(8'hAB, 12'b0_10101011_1_11);
        test_tx_frame(8'hFF, 12'b0_11111111_0_11);
        test_cts_hold();
        test_rx_basic();
        test_rx_errors();
        test_fifo_full();
        test_reset_midframe();
        test_bist(1'b0, 1'b0);
        test_bist(1'b1, 1'b1);
        test_bist(1'b0, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
